// File: rtl/period_timer_pkg.sv
// Shared types and defaults for the programmable period timer.
package period_timer_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : period_timer_pkg

// File: rtl/period_timer_if.sv
// Control/status bundle between a requester (master) and the period timer (slave).
interface period_timer_if
    import period_timer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic         start;
    logic [N-1:0] limit;
    logic         auto_reload;
    logic         ce;
    logic         stop;
    logic [N-1:0] count;
    logic         tick;
    logic         busy;
    logic         done;

    modport master (
        output start, limit, auto_reload, ce, stop,
        input  count, tick, busy, done
    );

    modport slave (
        input  start, limit, auto_reload, ce, stop,
        output count, tick, busy, done
    );
endinterface : period_timer_if

// File: rtl/period_timer_uge_n.sv
// N-bit unsigned greater-or-equal compare: carry-out of i0 + ~i1 + 1.
module uge_n #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] i0_i,
    input  logic [N-1:0] i1_i,
    output logic         ge_o
);
    logic [N:0] diff_s;

    // No borrow out of the subtract means i0 >= i1.
    assign diff_s = {1'b0, i0_i} + {1'b0, ~i1_i} + {{N{1'b0}}, 1'b1};
    assign ge_o   = diff_s[N];
endmodule : uge_n

// File: rtl/period_timer.sv
// Programmable period timer: counts CE cycles up to a latched limit, then ticks
// and either reloads (auto) or parks in DONE (one-shot).
module period_timer
    import period_timer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    period_timer_if.slave bus
);
    state_e       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] limit_q, limit_d;
    logic         auto_q, auto_d;
    logic         tick_q, tick_d;
    logic         term_s;
    logic [N-1:0] count_inc_s;
    logic         busy_s;
    logic         done_s;

    // Count never passes limit_q, so this increment cannot wrap in practice.
    assign count_inc_s = count_q + {{(N-1){1'b0}}, 1'b1};

    uge_n #(.N(N)) u_uge (
        .i0_i (count_q),
        .i1_i (limit_q),
        .ge_o (term_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; STOP outranks START, which outranks CE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.stop && bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.ce && term_s && !auto_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (bus.start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter, tick and latched configuration next values.
    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        auto_d  = auto_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.stop) begin
                    count_d = {N{1'b0}};
                end else if (bus.start) begin
                    limit_d = bus.limit;
                    auto_d  = bus.auto_reload;
                    count_d = {N{1'b0}};
                end else begin
                    count_d = count_q;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    count_d = {N{1'b0}};
                end else if (bus.ce) begin
                    if (term_s) begin
                        tick_d  = 1'b1;
                        count_d = auto_q ? {N{1'b0}} : count_q;
                    end else begin
                        count_d = count_inc_s;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            default: begin
                count_d = {N{1'b0}};
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {N{1'b0}};
            limit_q <= {N{1'b0}};
            auto_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            auto_q  <= auto_d;
            tick_q  <= tick_d;
        end
    end

    // Status decodes straight from the state register.
    always_comb begin
        busy_s = (state_q == ST_RUN);
        done_s = (state_q == ST_DONE);
    end

    assign bus.count = count_q;
    assign bus.tick  = tick_q;
    assign bus.busy  = busy_s;
    assign bus.done  = done_s;
endmodule : period_timer

// File: tb/tb_period_timer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-level reference model, and an exhaustive 4-bit compare sweep.
module tb_period_timer;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;

    period_timer_if #(.N(W)) bus_if ();

    period_timer #(.N(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    logic [3:0] cmp_a, cmp_b;
    logic       cmp_ge;

    uge_n #(.N(4)) u_cmp (
        .i0_i (cmp_a),
        .i1_i (cmp_b),
        .ge_o (cmp_ge)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (behavioural, plain integers and flags).
    bit m_run, m_fin, m_auto, m_tick;
    int m_cnt, m_lim;
    int ce_cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst_v, input bit start_v, input int lim_v,
                        input bit auto_v, input bit ce_v, input bit stop_v);
        rst                = rst_v;
        bus_if.start       = start_v;
        bus_if.limit       = lim_v[W-1:0];
        bus_if.auto_reload = auto_v;
        bus_if.ce          = ce_v;
        bus_if.stop        = stop_v;
        @(posedge clk);
        if (rst_v) begin
            m_run = 0; m_fin = 0; m_auto = 0; m_tick = 0;
            m_cnt = 0; m_lim = 0; ce_cycles = 0;
        end else if (m_run) begin
            if (stop_v) begin
                m_run = 0; m_cnt = 0; m_tick = 0;
            end else if (ce_v) begin
                ce_cycles++;
                if (m_cnt >= m_lim) begin
                    m_tick = 1;
                    if (m_auto) m_cnt = 0;
                    else begin m_run = 0; m_fin = 1; end
                end else begin
                    m_cnt++;
                    m_tick = 0;
                end
            end else begin
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
            if (stop_v) begin
                if (m_fin) m_cnt = 0;
                m_fin = 0;
            end else if (start_v) begin
                m_lim = lim_v; m_auto = auto_v; m_cnt = 0;
                m_run = 1; m_fin = 0; ce_cycles = 0;
            end
        end
        #1;
        chk("count", 32'(bus_if.count), 32'(m_cnt));
        chk("tick",  32'(bus_if.tick),  32'(m_tick));
        chk("busy",  32'(bus_if.busy),  32'(m_run));
        chk("done",  32'(bus_if.done),  32'(m_fin));
        if (bus_if.tick === 1'b1) begin
            chk("period", 32'(ce_cycles), 32'(m_lim + 1));
            ce_cycles = 0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        int first_tick, second_tick;
        rst = 1'b1;
        bus_if.start = 1'b0; bus_if.limit = '0; bus_if.auto_reload = 1'b0;
        bus_if.ce = 1'b0; bus_if.stop = 1'b0;
        m_run = 0; m_fin = 0; m_auto = 0; m_tick = 0; m_cnt = 0; m_lim = 0; ce_cycles = 0;

        // Reset state
        step(1, 0, 0, 0, 0, 0);
        chk("rst_count", 32'(bus_if.count), 32'd0);
        chk("rst_busy",  32'(bus_if.busy),  32'd0);
        step(0, 0, 0, 0, 1, 0);

        // One-shot, LIMIT=3
        step(0, 1, 3, 0, 1, 0);
        chk("os_c0", 32'(bus_if.count), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("os_ck", 32'(bus_if.count), 32'(k));
        end
        step(0, 0, 0, 0, 1, 0);
        chk("os_tick", 32'(bus_if.tick), 32'd1);
        chk("os_done", 32'(bus_if.done), 32'd1);
        chk("os_busy", 32'(bus_if.busy), 32'd0);
        chk("os_hold", 32'(bus_if.count), 32'd3);
        step(0, 0, 0, 0, 1, 0);
        chk("os_tick0", 32'(bus_if.tick), 32'd0);
        chk("os_done1", 32'(bus_if.done), 32'd1);
        step(0, 0, 0, 0, 0, 1);

        // Reset mid-run, LIMIT=5 auto
        step(0, 1, 5, 1, 1, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1, 0);
        chk("mr_c3", 32'(bus_if.count), 32'd3);
        step(1, 0, 0, 0, 1, 0);
        chk("mr_count", 32'(bus_if.count), 32'd0);
        chk("mr_tick",  32'(bus_if.tick),  32'd0);
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0, 0, 1, 0);
            ticks += int'(bus_if.tick);
        end
        chk("mr_noticks", 32'(ticks), 32'd0);

        // Auto reload, LIMIT=0
        step(0, 1, 0, 1, 1, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 1, 0);
            chk("l0_tick", 32'(bus_if.tick), 32'd1);
            chk("l0_cnt",  32'(bus_if.count), 32'd0);
        end
        step(0, 0, 0, 0, 0, 1);

        // Auto reload, LIMIT=255
        step(0, 1, 255, 1, 1, 0);
        ticks = 0; first_tick = -1; second_tick = -1;
        for (int k = 1; k <= 520; k++) begin
            step(0, 0, 0, 0, 1, 0);
            if (k == 255) chk("l255_max", 32'(bus_if.count), 32'd255);
            if (bus_if.tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = k;
                else if (second_tick < 0) second_tick = k;
            end
        end
        chk("l255_ticks", 32'(ticks), 32'd2);
        chk("l255_first", 32'(first_tick), 32'd256);
        chk("l255_gap", 32'(second_tick - first_tick), 32'd256);
        step(0, 0, 0, 0, 0, 1);

        // CE gating, LIMIT=2 auto, pattern 1,0,0,1,1
        step(0, 1, 2, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0); chk("ce_a", 32'(bus_if.count), 32'd1);
        step(0, 0, 0, 0, 0, 0); chk("ce_b", 32'(bus_if.count), 32'd1);
        step(0, 0, 0, 0, 0, 0); chk("ce_c", 32'(bus_if.tick),  32'd0);
        step(0, 0, 0, 0, 1, 0); chk("ce_d", 32'(bus_if.count), 32'd2);
        step(0, 0, 0, 0, 1, 0); chk("ce_tick", 32'(bus_if.tick), 32'd1);

        // STOP and START together while running
        step(0, 1, 9, 1, 1, 1);
        chk("ss_busy",  32'(bus_if.busy),  32'd0);
        chk("ss_count", 32'(bus_if.count), 32'd0);

        // START while running is ignored
        step(0, 1, 5, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 1, 0); chk("ir_c3", 32'(bus_if.count), 32'd3);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0); chk("ir_c5", 32'(bus_if.count), 32'd5);
        step(0, 0, 0, 0, 1, 0); chk("ir_tick", 32'(bus_if.tick), 32'd1);
        step(0, 0, 0, 0, 0, 1);

        // START from DONE with LIMIT=1
        step(0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0); chk("dn_done", 32'(bus_if.done), 32'd1);
        step(0, 1, 1, 0, 1, 0); chk("dn_busy", 32'(bus_if.busy), 32'd1);
        step(0, 0, 0, 0, 1, 0); chk("dn_t1", 32'(bus_if.tick), 32'd0);
        step(0, 0, 0, 0, 1, 0); chk("dn_t2", 32'(bus_if.tick), 32'd1);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int lim_r;
            lim_r = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7))
                                                : int'($urandom_range(0, 255));
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, lim_r,
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 39) == 0);
        end

        // Exhaustive 4-bit compare sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                cmp_a = 4'(a);
                cmp_b = 4'(b);
                #1;
                chk("uge4", 32'(cmp_ge), (a >= b) ? 32'd1 : 32'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_period_timer

// File: doc/period_timer.md
# period_timer

Programmable N-bit period timer built around an unsigned greater-or-equal compare stage. A START request latches a limit and a mode, then counts CE-qualified cycles. When the count reaches the limit, the block emits a one-cycle TICK and either reloads (auto mode) or stops in DONE (one-shot mode). It sits directly upstream of the unsigned compare stage: it produces the count operand, consumes the compare result, and uses that result as its terminal-count decision.

## Interface
- N, default 8: counter, limit and compare width in bits (N ≥ 2).
- CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset; overrides every other input.
- START  in  1  request to begin a period sequence (see Operation).
- LIMIT  in  N  terminal count, unsigned; sampled only when START is accepted.
- AUTO  in  1  mode, sampled with LIMIT: 1 = auto-reload, 0 = one-shot.
- CE  in  1  count enable; when low in RUN, COUNT and state hold.
- STOP  in  1  abort; returns to IDLE.
- COUNT  out  N  current count, registered.
- TICK  out  1  one-cycle pulse marking period completion, registered.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE (one-shot finished).

## Operation
- Internal registers: limit_q[N], auto_q, state ∈ {IDLE, RUN, DONE}, COUNT, TICK.
- Reset: state=IDLE, COUNT=0, TICK=0, limit_q=0, auto_q=0. Outputs after reset: BUSY=0, DONE=0.
- Decodes from state: BUSY = (state==RUN); DONE = (state==DONE).
- term = (COUNT ≥ limit_q), unsigned. It is produced by the compare sub-module as the carry-out of COUNT + ~limit_q + 1.
- Input priority each cycle: RESET > STOP > START > CE.

IDLE:
- START=1: limit_q←LIMIT, auto_q←AUTO, COUNT←0, state←RUN.
- Otherwise: hold, TICK←0.

RUN:
- STOP=1: state←IDLE, COUNT←0, TICK←0.
- START is ignored; there is no restart while running.
- CE=0: COUNT holds, TICK←0.
- CE=1 and term=0: COUNT←COUNT+1, TICK←0.
- CE=1, term=1 and auto_q=1: COUNT←0, TICK←1, state stays RUN.
- CE=1, term=1 and auto_q=0: COUNT holds at limit_q, TICK←1, state←DONE.

DONE:
- STOP=1: state←IDLE, COUNT←0.
- START=1: relatch LIMIT and AUTO, COUNT←0, state←RUN.
- Otherwise: hold. TICK←0 on every DONE cycle.

Width and boundary rules:
- The increment is modulo 2^N, but COUNT never exceeds limit_q, so there is no wrap through 2^N.
- LIMIT=2^N−1: COUNT reaches all-ones, then reloads to 0 (auto mode) or holds (one-shot).
- LIMIT=0: term is true on the first CE cycle. TICK fires every CE cycle in auto mode.
- Period = limit_q+1 CE-qualified cycles.
- STOP and START in the same cycle: STOP wins. START must be reasserted afterwards.
- RESET mid-sequence: all state returns to reset values at the next edge; no TICK is generated.

## Timing
- All outputs are registered or decoded from state; no combinational input-to-output paths.
- START accepted at edge t: BUSY=1 and COUNT=0 are visible after edge t.
- With CE held high, COUNT=k after edge t+k, for k ≤ L.
- The terminal edge is t+L+1. After it:
  - TICK=1 for one cycle.
  - One-shot: BUSY=0 and DONE=1.
  - Auto: COUNT=0, and the next TICK follows after edge t+2(L+1).
- CE low cycles stretch the period 1:1 and never produce TICK.

## Structure
- Shared package holds:
  - the state enum {IDLE, RUN, DONE} (2-bit encoding);
  - the width parameter default N=8.
- One sub-module, uge_n: parameterised N-bit unsigned ≥ compare.
  - Implemented as an N-bit subtract (invert operand B, carry-in 1), returning the carry-out only.
  - Instantiated once, with I0=COUNT and I1=limit_q.
- Incrementer, next-state logic and registers live in period_timer.

## Test plan
- Reset mid-run (N=8, LIMIT=5, AUTO=1, CE=1): RESET at COUNT=3 → next cycle COUNT=0, BUSY=0, DONE=0, TICK=0; no TICK afterwards.
- One-shot (LIMIT=3, AUTO=0, CE=1, START at edge 0): COUNT 0,1,2,3 after edges 0–3; after edge 4 TICK=1, DONE=1, BUSY=0, COUNT=3; after edge 5 TICK=0, DONE=1.
- Auto-reload at LIMIT=0 and LIMIT=255: TICK high every cycle with COUNT=0 (LIMIT=0); for LIMIT=255, TICK every 256 cycles and COUNT goes 255→0 with no overflow glitch.
- CE gating (LIMIT=2, AUTO=1, CE pattern 1,0,0,1,1): COUNT holds during the CE=0 cycles; TICK asserts only after the third CE=1 edge.
- Control priority: STOP+START together in RUN → IDLE, COUNT=0. START in RUN is ignored (limit_q unchanged). START in DONE with LIMIT=1 → RUN, with TICK two cycles later.
- Random compare sweep (N=4): every (COUNT, limit_q) pair checks term == (COUNT ≥ limit_q); the period always equals limit_q+1.
